// File: rtl/ps2_host_tx_if.sv
// Host-to-device PS/2 transmitter interface: command byte handshake,
// transfer status and the open-drain line controls.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic [1:0] err;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  // Transmitter side
  modport slave (
    input  tx_data, tx_valid, ps2_clk_i, ps2_data_i,
    output tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe
  );

  // Command source / line side
  modport master (
    output tx_data, tx_valid, ps2_clk_i, ps2_data_i,
    input  tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 10-bit serialization on
// device clock falls, ACK check, return-to-idle wait and overall timeout.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | lines released, ready for a command byte
// S_INHIBIT   | clock pulled low for INHIBIT_CYCLES
// S_REQ       | clock and data (start bit) low for SETUP_CYCLES
// S_SEND      | clock released; data/parity/stop driven on each fall
// S_ACK       | data sampled on the next fall (0 = device ACK)
// S_WAIT_IDLE | waiting for both lines high, then done
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic          clk,
  input  logic          reset_n,
  ps2_host_tx_if.slave  bus
);

  localparam int PH_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_SEND      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_clk_s1;
  logic            r_clk_s2;
  logic            r_clk_prev;
  logic            r_data_s1;
  logic            r_data_s2;

  logic [9:0]      r_frame;
  logic [3:0]      r_idx;
  logic            r_drive_low;
  logic            r_ack_err;
  logic            r_done;
  logic [1:0]      r_err;
  logic [PH_W-1:0] r_ph_cnt;
  logic [TO_W-1:0] r_to_cnt;

  logic            w_fall;
  logic            w_accept;
  logic            w_in_xfer;
  logic            w_ph_tc;
  logic            w_to_tc;
  logic            w_lines_idle;

  assign w_fall       = r_clk_prev & ~r_clk_s2;
  assign w_accept     = bus.tx_valid & (r_state == S_IDLE);
  assign w_in_xfer    = (r_state == S_SEND) | (r_state == S_ACK) | (r_state == S_WAIT_IDLE);
  assign w_ph_tc      = (r_ph_cnt == '0);
  assign w_to_tc      = w_in_xfer & (r_to_cnt == '0);
  assign w_lines_idle = r_clk_s2 & r_data_s2;

  // Two-flop synchronizers on the raw lines plus the previous clock sample;
  // reset to the released (high) level so no false fall follows reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_data_s1  <= 1'b1;
      r_data_s2  <= 1'b1;
    end else begin
      r_clk_s1   <= bus.ps2_clk_i;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_data_s1  <= bus.ps2_data_i;
      r_data_s2  <= r_data_s1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; the timeout wins over a fall on the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_INHIBIT;
      end
      S_INHIBIT: begin
        if (w_ph_tc) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_ph_tc) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_to_tc)                          w_state_nxt = S_IDLE;
        else if (w_fall && (r_idx == 4'd9))   w_state_nxt = S_ACK;
      end
      S_ACK: begin
        if (w_to_tc)     w_state_nxt = S_IDLE;
        else if (w_fall) w_state_nxt = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (w_to_tc)           w_state_nxt = S_IDLE;
        else if (w_lines_idle) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame latch, phase/timeout down-counters, bit shifting, ACK capture
  // and the done/err status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame     <= '0;
      r_idx       <= '0;
      r_drive_low <= 1'b0;
      r_ack_err   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 2'b00;
      r_ph_cnt    <= '0;
      r_to_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_to_tc) begin
        r_done      <= 1'b1;
        r_err       <= 2'b10;
        r_drive_low <= 1'b0;
      end else begin
        if (w_in_xfer) r_to_cnt <= r_to_cnt - 1'b1;
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_frame   <= {1'b1, ~^bus.tx_data, bus.tx_data};
              r_ack_err <= 1'b0;
              r_ph_cnt  <= PH_W'(INHIBIT_CYCLES - 1);
            end
          end
          S_INHIBIT: begin
            if (w_ph_tc) r_ph_cnt <= PH_W'(SETUP_CYCLES - 1);
            else         r_ph_cnt <= r_ph_cnt - 1'b1;
          end
          S_REQ: begin
            if (w_ph_tc) begin
              r_idx       <= '0;
              r_to_cnt    <= TO_W'(TIMEOUT_CYCLES - 1);
              r_drive_low <= 1'b1;
            end else begin
              r_ph_cnt <= r_ph_cnt - 1'b1;
            end
          end
          S_SEND: begin
            if (w_fall) begin
              r_drive_low <= ~r_frame[r_idx];
              r_idx       <= r_idx + 4'd1;
            end
          end
          S_ACK: begin
            if (w_fall) r_ack_err <= r_data_s2;
          end
          S_WAIT_IDLE: begin
            if (w_lines_idle) begin
              r_done <= 1'b1;
              r_err  <= {1'b0, r_ack_err};
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs decoded from state so an asynchronous reset releases the lines
  // at once; data stays low through REQ and into SEND until the first fall.
  always_comb begin
    bus.tx_ready    = (r_state == S_IDLE);
    bus.busy        = (r_state != S_IDLE);
    bus.ps2_clk_oe  = (r_state == S_INHIBIT) | (r_state == S_REQ);
    bus.ps2_data_oe = (r_state == S_REQ) | ((r_state == S_SEND) & r_drive_low);
    bus.done        = r_done;
    bus.err         = r_err;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a PS/2 device model.
module tb_ps2_host_tx;
  localparam int INH   = 40;
  localparam int SETUP = 8;
  localparam int TO    = 2000;
  localparam int H     = 15;
  localparam int BOUND = 5000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;

  ps2_host_tx_if bus();

  always #5 clk = ~clk;

  // Open-drain wired-AND of host pull-downs and device drivers.
  assign bus.ps2_clk_i  = ~bus.ps2_clk_oe & dev_clk;
  assign bus.ps2_data_i = ~bus.ps2_data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int cyc = 0, inh_run = 0, last_inh = 0, set_run = 0, last_set = 0, rel_cyc = 0;
  int done_cnt = 0, done_cyc = 0, acc_cnt = 0, b2b_hits = 0;
  logic [1:0] done_err = 2'b00;
  logic [1:0] done_oe = 2'b00;
  logic done_ready = 1'b0;
  logic prev_clk_oe = 1'b0;

  // Observe line phases, accepts and done pulses between clock edges.
  always @(negedge clk) begin
    cyc++;
    if (bus.ps2_clk_oe && !bus.ps2_data_oe) inh_run++;
    else begin if (inh_run != 0) last_inh = inh_run; inh_run = 0; end
    if (bus.ps2_clk_oe && bus.ps2_data_oe) set_run++;
    else begin if (set_run != 0) last_set = set_run; set_run = 0; end
    if (prev_clk_oe && !bus.ps2_clk_oe) rel_cyc = cyc;
    prev_clk_oe = bus.ps2_clk_oe;
    if (bus.tx_valid && bus.tx_ready) acc_cnt++;
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc   = cyc;
      done_err   = bus.err;
      done_ready = bus.tx_ready;
      done_oe    = {bus.ps2_clk_oe, bus.ps2_data_oe};
      if (bus.tx_valid) b2b_hits++;
    end
  end

  // Expected wire frame: 8 data bits LSB first, odd parity, stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic start_tx(input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && w < BOUND) begin @(negedge clk); w++; end
    if (w >= BOUND) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_wait: tx_ready never seen, waited %0d cycles", w);
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // Device: wait for request-to-send, clock 10 bits in, then ACK fall.
  task automatic device_xfer(input bit do_clock, input bit do_ack, input int abort_bit,
                             output logic [9:0] rx, output bit aborted);
    int w = 0;
    rx = '0;
    aborted = 1'b0;
    while (!(bus.ps2_clk_oe === 1'b0 && bus.ps2_data_oe === 1'b1) && w < BOUND) begin
      @(negedge clk); w++;
    end
    if (w >= BOUND) begin
      n_cmp++; n_bad++;
      $display("FAIL req_wait: no request-to-send within %0d cycles", w);
      return;
    end
    if (!do_clock) return;
    for (int k = 0; k < 10; k++) begin
      repeat (H) @(negedge clk);
      dev_clk = 1'b0;
      if (k == abort_bit) begin
        repeat (6) @(negedge clk);
        n_cmp++;
        if (bus.ps2_data_oe !== 1'b1) begin
          n_bad++;
          $display("FAIL pre_reset_oe: data_oe=%b expected 1", bus.ps2_data_oe);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.ps2_clk_oe, bus.ps2_data_oe} !== 2'b00) begin
          n_bad++;
          $display("FAIL async_release: oe=%b expected 00", {bus.ps2_clk_oe, bus.ps2_data_oe});
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        dev_clk = 1'b1;
        aborted = 1'b1;
        return;
      end
      repeat (H) @(negedge clk);
      rx[k] = bus.ps2_data_i;
      dev_clk = 1'b1;
    end
    repeat (H / 2) @(negedge clk);
    if (do_ack) dev_data = 1'b0;
    repeat (H - H / 2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (H) @(negedge clk);
    dev_clk = 1'b1;
    repeat (2) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input int target);
    int w = 0;
    while (done_cnt < target && w < BOUND) begin @(negedge clk); w++; end
    if (done_cnt < target) begin
      n_cmp++; n_bad++;
      $display("FAIL done_wait: done count %0d expected %0d", done_cnt, target);
    end
  endtask

  task automatic run_xfer(input logic [7:0] b, input bit ack, output logic [9:0] rx);
    int start = done_cnt;
    bit ab;
    last_inh = 0;
    last_set = 0;
    fork
      start_tx(b);
      device_xfer(1'b1, ack, -1, rx, ab);
    join
    wait_done(start + 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.tx_ready, bus.busy, bus.done} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_hs: ready/busy/done=%b expected 100", {bus.tx_ready, bus.busy, bus.done});
    end
    n_cmp++;
    if ({bus.err, bus.ps2_clk_oe, bus.ps2_data_oe} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_lines: err/oe=%b expected 0000", {bus.err, bus.ps2_clk_oe, bus.ps2_data_oe});
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done_cnt !== 0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset: done_cnt=%0d busy=%b expected 0 0", done_cnt, bus.busy);
    end
  endtask

  task automatic test_basic_ed;
    logic [9:0] rx;
    run_xfer(8'hED, 1'b1, rx);
    n_cmp++;
    if (last_inh != INH) begin n_bad++; $display("FAIL inhibit_len: got %0d expected %0d", last_inh, INH); end
    n_cmp++;
    if (last_set != SETUP) begin n_bad++; $display("FAIL setup_len: got %0d expected %0d", last_set, SETUP); end
    n_cmp++;
    if (rx !== 10'b1_1_11101101) begin n_bad++; $display("FAIL frame_ed: got %b expected %b", rx, 10'b1_1_11101101); end
    n_cmp++;
    if (done_err !== 2'b00 || done_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL done_ed: err=%b ready=%b expected 00 1", done_err, done_ready);
    end
  endtask

  task automatic test_parity_f4;
    logic [9:0] rx;
    run_xfer(8'hF4, 1'b1, rx);
    n_cmp++;
    if (rx[8] !== 1'b0) begin n_bad++; $display("FAIL parity_f4: got %b expected 0", rx[8]); end
    n_cmp++;
    if (rx !== ref_frame(8'hF4)) begin n_bad++; $display("FAIL frame_f4: got %b expected %b", rx, ref_frame(8'hF4)); end
    n_cmp++;
    if (done_err !== 2'b00 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_f4: err=%b busy=%b expected 00 0", done_err, bus.busy);
    end
  endtask

  task automatic test_noack;
    logic [9:0] rx;
    logic [7:0] b = 8'($urandom);
    run_xfer(b, 1'b0, rx);
    n_cmp++;
    if (done_err !== 2'b01) begin n_bad++; $display("FAIL noack_err: got %b expected 01", done_err); end
    n_cmp++;
    if (rx !== ref_frame(b)) begin n_bad++; $display("FAIL frame_noack: got %b expected %b", rx, ref_frame(b)); end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus.err !== 2'b01 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL err_hold: err=%b done=%b expected 01 0", bus.err, bus.done);
    end
  endtask

  task automatic test_timeout;
    logic [9:0] rx;
    bit ab;
    int start = done_cnt;
    fork
      start_tx(8'($urandom));
      device_xfer(1'b0, 1'b0, -1, rx, ab);
    join
    wait_done(start + 1);
    n_cmp++;
    if (done_cyc - rel_cyc != TO) begin
      n_bad++;
      $display("FAIL timeout_len: got %0d expected %0d", done_cyc - rel_cyc, TO);
    end
    n_cmp++;
    if (done_err !== 2'b10 || done_oe !== 2'b00) begin
      n_bad++;
      $display("FAIL timeout_status: err=%b oe=%b expected 10 00", done_err, done_oe);
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] rx;
    bit ab = 1'b0;
    int start = done_cnt;
    fork
      start_tx(8'($urandom) & 8'hEF);
      device_xfer(1'b1, 1'b1, 4, rx, ab);
    join
    repeat (30) @(negedge clk);
    n_cmp++;
    if (!ab || bus.tx_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_state: aborted=%b ready=%b busy=%b expected 1 1 0", ab, bus.tx_ready, bus.busy);
    end
    n_cmp++;
    if (done_cnt != start) begin n_bad++; $display("FAIL reset_mid_done: got %0d pulses expected 0", done_cnt - start); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] rx1, rx2;
    bit ab;
    int start = done_cnt;
    int hits = b2b_hits;
    fork
      begin start_tx(8'hFF); start_tx(8'h11); end
      begin device_xfer(1'b1, 1'b1, -1, rx1, ab); device_xfer(1'b1, 1'b1, -1, rx2, ab); end
    join
    wait_done(start + 2);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rx1 !== ref_frame(8'hFF)) begin n_bad++; $display("FAIL b2b_first: got %b expected %b", rx1, ref_frame(8'hFF)); end
    n_cmp++;
    if (rx2 !== ref_frame(8'h11)) begin n_bad++; $display("FAIL b2b_second: got %b expected %b", rx2, ref_frame(8'h11)); end
    n_cmp++;
    if (done_cnt != start + 2 || done_err !== 2'b00) begin
      n_bad++;
      $display("FAIL b2b_done: pulses=%0d err=%b expected 2 00", done_cnt - start, done_err);
    end
    n_cmp++;
    if (b2b_hits != hits + 1) begin
      n_bad++;
      $display("FAIL b2b_ready_at_done: got %0d expected 1", b2b_hits - hits);
    end
  endtask

  task automatic test_random;
    logic [9:0] rx;
    logic [7:0] b;
    bit ack;
    for (int i = 0; i < 4; i++) begin
      b   = 8'($urandom);
      ack = 1'($urandom_range(0, 1));
      run_xfer(b, ack, rx);
      n_cmp++;
      if (rx !== ref_frame(b)) begin n_bad++; $display("FAIL rand_frame[%0d]: got %b expected %b", i, rx, ref_frame(b)); end
      n_cmp++;
      if (done_err !== {1'b0, ~ack}) begin
        n_bad++;
        $display("FAIL rand_err[%0d]: got %b expected %b", i, done_err, {1'b0, ~ack});
      end
    end
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    test_reset();
    test_basic_ed();
    test_parity_f4();
    test_noack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global time limit");
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device transmitter for the PS/2 port; the write direction of the PS/2 interface.
- Accepts one command byte from the Avalon slave register logic, performs the PS/2 request-to-send sequence and serializes the 11-bit frame on device-generated clock edges.
- Checks the device ACK bit and reports done and error status.
- Drives the open-drain PS/2 lines through active-high pull-low enables. The line receiver ignores traffic while busy is high.

Parameters:
- INHIBIT_CYCLES, 5000: clk periods ps2 clock is held low before the request (100 us at 50 MHz).
- SETUP_CYCLES, 50: clk periods with both lines low before ps2 clock is released.
- TIMEOUT_CYCLES, 750000: maximum clk periods from clock release to return-to-idle (15 ms at 50 MHz).

Ports:
- clk, input, 1: system clock; the only clock.
- reset_n, input, 1: asynchronous, active-low reset.
- tx_data, input, 8: command byte.
- tx_valid, input, 1: tx_data valid.
- tx_ready, output, 1: block can accept a byte.
- busy, output, 1: transmission in progress.
- done, output, 1: one-cycle pulse at end of transfer.
- err, output, 2: valid with done; bit0 = no device ACK, bit1 = timeout.
- ps2_clk_i, input, 1: raw PS/2 clock line.
- ps2_data_i, input, 1: raw PS/2 data line.
- ps2_clk_oe, output, 1: 1 pulls PS/2 clock low.
- ps2_data_oe, output, 1: 1 pulls PS/2 data low.

Behaviour:
Reset:
- tx_ready=1, busy=0, done=0, err=0, ps2_clk_oe=0, ps2_data_oe=0, state=IDLE.
- Synchronizer flops and the previous-clock sample reset to 1.
- Reset asserted mid-transfer releases both lines immediately (asynchronous).

Input sampling:
- ps2_clk_i and ps2_data_i each pass through a 2-flop synchronizer.
- fall = previous synchronized clk is 1 and current synchronized clk is 0.

Handshake:
- Transfer accepted on the cycle tx_valid && tx_ready.
- That cycle the block latches frame = {1'b1 stop, ~^tx_data odd parity, tx_data}, 10 bits, LSB sent first.
- tx_ready=1 only in IDLE; busy = (state != IDLE).

States:
- IDLE: both lines released. On accept, go to INHIBIT and clear the cycle counter.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ: clk_oe=1, data_oe=1 (start bit) for SETUP_CYCLES cycles. Then clk_oe=0, bit index=0, timeout counter cleared, go to SEND.
- SEND:
  - On each fall: data_oe <= ~frame[idx], idx++.
  - After the fall that drives idx 9 (stop, data released), go to ACK.
  - Data changes only on fall.
- ACK: on the next fall, sample synchronized data. 0 means ACK OK; 1 sets ack_err. Go to WAIT_IDLE.
- WAIT_IDLE: wait until synchronized clk=1 and data=1 on the same cycle. Then pulse done=1 with err={1'b0, ack_err} and go to IDLE.

Timeout:
- Counts every cycle in SEND, ACK and WAIT_IDLE.
- On reaching TIMEOUT_CYCLES: release both lines, pulse done with err[1]=1 (err[0]=0), go to IDLE.
- Timeout takes priority over a fall on the same cycle.

Boundary conditions:
- tx_valid while busy: ignored, not latched; the source must hold it.
- Glitch-free edges are assumed only after the synchronizer; no extra debounce.
- err holds its value until the next done; ack_err is cleared on accept.
- Throughput: done is followed by tx_ready=1 in the same cycle, so a new byte can be accepted on the next cycle.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz -> clk_oe low for 5000 cycles, then data_oe=1 for 50 cycles. Data bits on successive falls 1,0,1,1,0,1,1,1, parity 1, stop released. Device ACK low -> done pulse, err=00.
- Send 0xF4 -> parity bit driven as 0 (data_oe=1 on the 9th fall), err=00, busy low after both lines idle.
- Device never ACKs (data stays high on ACK fall) -> done with err=01.
- Device never clocks after release -> done exactly TIMEOUT_CYCLES cycles after clock release, err=10, both oe=0.
- Pulse reset_n low during SEND bit 4 -> oe outputs 0 immediately; after release tx_ready=1 and no done pulse.
- tx_valid asserted with 0x11 during a 0xFF transfer -> 0x11 not sent until accepted in IDLE; the frames sent are 0xFF then 0x11, two done pulses.
